dii_ring_mux_rr: RTL and testbench
==================================

Name: dii_ring_mux_rr

Overview:
- Parametrised N-input worm-aware multiplexer for the debug interconnect.
- Merges NUM_IN dii packet streams (flits marked first/last) onto one output channel without interleaving worms.
- Arbitrates between inputs round-robin.
- Successor to the fixed two-input ring/local mux. Used in ring routers with several local endpoints and in tree concentrators.

Parameters:
- NUM_IN, 2, number of input channels (2..16)
- WIDTH, 16, flit data width in bits
- SEL_W, $clog2(NUM_IN), width of the selection index (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  NUM_IN*WIDTH  input flits; channel i occupies bits [i*WIDTH +: WIDTH]
- in_first  in  NUM_IN  first-flit marker per channel
- in_last  in  NUM_IN  last-flit marker per channel
- in_valid  in  NUM_IN  flit valid per channel
- in_ready  out  NUM_IN  flit accepted per channel
- out_data  out  WIDTH  output flit
- out_first  out  1  output first marker
- out_last  out  1  output last marker
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- out_sel  out  SEL_W  index of the channel currently driving out (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, sel=0, rr_ptr=NUM_IN-1; out_valid=0, in_ready=0.
- Outputs out_data/out_first/out_last are don't-care when out_valid=0.
- Datapath: combinational pass-through, zero latency. A flit transfers on a channel when valid & ready are both high in the same cycle.
- States: IDLE, LOCKED. Registers: sel (SEL_W), rr_ptr (SEL_W).
- IDLE, candidate set: channels with in_valid[i] & in_first[i]. Channels that are valid but not first are never candidates and see in_ready=0 (they stall, nothing is dropped).
- IDLE, arbitration: winner = first candidate scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
- IDLE, with a winner w: out driven from w, out_valid=1, in_ready[w]=out_ready, all other in_ready=0, out_sel=w.
- IDLE, winner accepted (out_ready=1): rr_ptr<=w.
  - If in_last[w]=1 (single-flit worm): stay IDLE.
  - Else: sel<=w, go to LOCKED.
- IDLE, winner not accepted (out_ready=0): sel<=w, go to LOCKED. The offered flit stays on out next cycle; out_valid is never withdrawn and the source never changes while a flit is pending. rr_ptr<=w is written here as well.
- IDLE, no candidates: out_valid=0, out_sel=rr_ptr.
- LOCKED: out mirrors channel sel.
  - out_valid=in_valid[sel], in_ready[sel]=out_ready, all other in_ready=0.
  - Exit to IDLE on transfer with in_last[sel]=1.
  - A bubble (in_valid[sel]=0) holds the lock.
  - A first=1 flit arriving mid-worm is passed through unchanged; protocol checking is not this block's job.
- Fairness: a continuously requesting channel waits at most NUM_IN-1 worms.
- Simultaneous events: a worm's last flit and a new first flit on the same cycle cannot both transfer. The next worm is arbitrated in the following IDLE cycle, giving one arbitration cycle per worm (matches the predecessor).
- Reset mid-worm: returns to IDLE immediately. The partial worm downstream is not terminated; upstream and downstream are reset by the same rst.
- NUM_IN not a power of two: pointer increment wraps at NUM_IN-1 to 0, never at 2^SEL_W.

Optional Feature:
- Macro: DII_RING_MUX_CH0_PRIO_EN.
- Defined: channel 0 (the ring input) has strict priority in IDLE. If channel 0 is a candidate it wins regardless of rr_ptr, and rr_ptr is not updated for that grant. Round-robin applies among channels 1..NUM_IN-1 only when channel 0 is not a candidate.
- Not defined: pure round-robin over all channels as above.

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0 and in_ready=0 during reset. First grant after reset goes to channel 0.
- Round-robin, NUM_IN=4, all channels offer continuous 3-flit worms, out_ready=1 -> out_sel order 0,1,2,3,0,... Each worm contiguous. No flit interleaving; out_last on every 3rd flit.
- Backpressure in IDLE: channel 2 offers first flit 0xA5A5 with out_ready=0 for 5 cycles while channel 1 starts requesting -> out_data stays 0xA5A5 and out_sel stays 2 throughout. Channel 1 is served only after channel 2's last flit.
- Single-flit worms: channels 0 and 3 each offer first&last flits continuously -> alternating grants 0,3,0,3. State stays IDLE.
- Bubble and stray flit: LOCKED on channel 1 with in_valid gap of 3 cycles mid-worm, while channel 0 holds a valid non-first flit -> lock held through the gap, in_ready[0]=0 throughout, worm completes.
- DII_RING_MUX_CH0_PRIO_EN defined, channels 0 and 2 both requesting back-to-back worms -> channel 0 always wins. With channel 0 idle, channels 1 and 2 alternate.

Source files
------------

// File: rtl/dii_ring_mux_rr.sv
// rtl/dii_ring_mux_rr.sv - N-input worm-aware round-robin multiplexer for dii packet streams
// Optional DII_RING_MUX_CH0_PRIO_EN: channel 0 (ring input) takes strict priority when idle.
module dii_ring_mux_rr #(
    parameter int NUM_IN = 2,
    parameter int WIDTH  = 16,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_first,
    input  logic [NUM_IN-1:0]       in_last,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_first,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_sel
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel, sel_nxt;
    logic [SEL_W-1:0]  rr_ptr, rr_nxt;
    logic [SEL_W-1:0]  win, idx, src;
    logic [NUM_IN-1:0] cand;
    logic              found;

    // Only worm heads may open a new grant; body flits of other channels stall.
    assign cand = in_valid & in_first;

    always_comb begin : arbitrate
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`ifdef DII_RING_MUX_CH0_PRIO_EN
        if (cand[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
    end

    always_comb begin : control
        state_nxt = state;
        sel_nxt   = sel;
        rr_nxt    = rr_ptr;
        src       = sel;
        out_valid = 1'b0;
        in_ready  = '0;
        out_sel   = sel;
        case (state)
            IDLE: begin
                out_sel = rr_ptr;
                if (found) begin
                    src           = win;
                    out_valid     = 1'b1;
                    in_ready[win] = out_ready;
                    out_sel       = win;
`ifdef DII_RING_MUX_CH0_PRIO_EN
                    if (!cand[0]) rr_nxt = win;
`else
                    rr_nxt = win;
`endif
                    // A stalled head also locks, so the offered flit cannot change source.
                    if (!(out_ready && in_last[win])) begin
                        sel_nxt   = win;
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                out_valid     = in_valid[sel];
                in_ready[sel] = out_ready;
                if (in_valid[sel] && out_ready && in_last[sel]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            out_valid = 1'b0;
            in_ready  = '0;
        end
    end

    assign out_data  = in_data[int'(src)*WIDTH +: WIDTH];
    assign out_first = in_first[src];
    assign out_last  = in_last[src];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= SEL_W'(NUM_IN - 1);
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_nxt;
        end
    end

endmodule

// File: tb/tb_dii_ring_mux_rr.sv
// tb/tb_dii_ring_mux_rr.sv - self-checking bench for dii_ring_mux_rr with a behavioural model
// Build with DII_RING_MUX_CH0_PRIO_EN defined to check the channel-0 priority variant.
module tb_dii_ring_mux_rr;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = 2;
`ifdef DII_RING_MUX_CH0_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_first, in_last, in_valid, in_ready;
    logic [W-1:0]   out_data;
    logic           out_first, out_last, out_valid, out_ready;
    logic [SW-1:0]  out_sel;

    dii_ring_mux_rr #(.NUM_IN(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_first(in_first), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_first(out_first),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         f;
        logic         l;
    } flit_t;

    flit_t        q[N][$];
    int           vprob = 100;
    int           rprob = 100;
    logic [N-1:0] hold_off = '0;
    logic [N-1:0] fired = '0;
    int           checks = 0;
    int           errors = 0;

    // model state and observation log
    int           m_locked = 0;
    int           m_sel = 0;
    int           m_rr = N - 1;
    int           gl[$];
    int           n_xfer = 0;
    int           n_last = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        if (PRIO && in_valid[0] && in_first[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (in_valid[j] && in_first[j]) return j;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int           w, src, exp_sel;
        logic         ev;
        logic [N-1:0] er;
        fired = in_valid & in_ready;
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            m_locked = 0;
            m_sel    = 0;
            m_rr     = N - 1;
        end else begin
            w = -1;
            if (m_locked == 0) begin
                w   = pick();
                src = w;
                ev  = (w >= 0);
            end else begin
                src = m_sel;
                ev  = in_valid[src];
            end
            er = '0;
            if (src >= 0) er[src] = out_ready;
            exp_sel = (src >= 0) ? src : m_rr;
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, er);
            chk("out_sel", out_sel, exp_sel);
            if (ev) begin
                chk("out_data", out_data, in_data[src*W +: W]);
                chk("out_first", out_first, in_first[src]);
                chk("out_last", out_last, in_last[src]);
                if (out_ready) begin
                    n_xfer++;
                    if (in_last[src]) n_last++;
                    if (in_first[src]) gl.push_back(src);
                end
            end
            if (m_locked == 0 && w >= 0) begin
                if (!(PRIO && w == 0)) m_rr = w;
                if (!(out_ready && in_last[w])) begin
                    m_locked = 1;
                    m_sel    = w;
                end
            end else if (m_locked != 0 && in_valid[m_sel] && out_ready && in_last[m_sel]) begin
                m_locked = 0;
            end
        end
    end

    task automatic drive();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            if (hold_off[i] || q[i].size() == 0) v[i] = 1'b0;
            else if (in_valid[i] && !fired[i]) v[i] = 1'b1;
            else v[i] = ($urandom_range(99) < vprob);
            if (q[i].size() > 0) begin
                in_data[i*W +: W] = q[i][0].d;
                in_first[i]       = q[i][0].f;
                in_last[i]        = q[i][0].l;
            end else begin
                in_data[i*W +: W] = W'($urandom);
                in_first[i]       = 1'($urandom);
                in_last[i]        = 1'($urandom);
            end
        end
        in_valid  = v;
        out_ready = ($urandom_range(99) < rprob);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (fired[i] && q[i].size() > 0) void'(q[i].pop_front());
        drive();
    endtask

    function automatic bit drained(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++)
            if (mask[i] && q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until(input logic [N-1:0] mask, input int budget, input string name,
                             output int used);
        used = 0;
        while (!drained(mask) && used < budget) begin
            step();
            used++;
        end
        checks++;
        if (!drained(mask)) begin
            errors++;
            $display("FAIL %s: queues not drained after %0d cycles", name, used);
        end
    endtask

    task automatic load(input int ch, input int worms, input int len, input int tag);
        for (int wi = 0; wi < worms; wi++)
            for (int k = 0; k < len; k++) begin
                flit_t fl;
                fl.d = {4'(tag), 4'(wi), 8'(ch * 16 + k)};
                fl.f = (k == 0);
                fl.l = (k == len - 1);
                q[ch].push_back(fl);
            end
    endtask

    function automatic logic [63:0] grants();
        logic [63:0] g;
        g = '0;
        foreach (gl[i]) g = (g << 4) | 64'(gl[i]);
        return g;
    endfunction

    initial begin
        int used;
        in_data = '0; in_first = '0; in_last = '0; in_valid = '0; out_ready = 1'b0;

        // reset with every channel offering a 3-flit worm head, then round-robin
        for (int i = 0; i < N; i++) load(i, 4, 3, 1);
        rst = 1'b1;
        drive();
        step();
        step();
        rst = 1'b0;
        gl.delete(); n_xfer = 0; n_last = 0;
        run_until('1, 200, "rr_drain", used);
        chk("rr_first_grant", gl.size() > 0 ? gl[0] : -1, 0);
        chk("rr_order", grants(), PRIO ? 64'h0000123123123123 : 64'h0123012301230123);
        chk("rr_worms", gl.size(), 16);
        chk("rr_flits", n_xfer, 48);
        chk("rr_lasts", n_last, 16);

        // backpressure on an idle grant: source must not change while pending
        q[2].push_back('{16'hA5A5, 1'b1, 1'b0});
        q[2].push_back('{16'h0202, 1'b0, 1'b0});
        q[2].push_back('{16'h0203, 1'b0, 1'b1});
        load(1, 1, 2, 2);
        gl.delete();
        rprob = 0;
        hold_off[1] = 1'b1;
        drive();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_data", out_data, 16'hA5A5);
            chk("bp_sel", out_sel, 2);
            chk("bp_valid", out_valid, 1);
            hold_off[1] = 1'b0;
            if (c < 4) step();
        end
        rprob = 100;
        run_until(4'b0110, 50, "bp_drain", used);
        chk("bp_order", grants(), 64'h21);

        // single-flit worms on channels 0 and 3 need no lock cycle
        load(0, 4, 1, 3);
        load(3, 4, 1, 3);
        gl.delete();
        drive();
        run_until(4'b1001, 50, "single_drain", used);
        chk("single_order", grants(), PRIO ? 64'h00003333 : 64'h30303030);
        chk("single_cycles", used, 8);

        // bubble mid-worm on channel 1 with a stray body flit parked on channel 0
        q[0].push_back('{16'h5555, 1'b0, 1'b0});
        load(1, 1, 4, 4);
        gl.delete();
        drive();
        while (q[1].size() > 2 && used < 100) begin
            step();
            used++;
        end
        hold_off[1] = 1'b1;
        drive();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bubble_ready0", in_ready[0], 0);
            chk("bubble_valid", out_valid, 0);
            chk("bubble_sel", out_sel, 1);
            if (c < 2) step();
        end
        hold_off[1] = 1'b0;
        run_until(4'b0010, 50, "bubble_drain", used);
        chk("bubble_stray_kept", q[0].size(), 1);
        chk("bubble_order", grants(), 64'h1);
        q[0].delete();
        drive();

        // channel 0 against channel 2, then 1 against 2
        load(0, 3, 2, 5);
        load(2, 3, 2, 5);
        gl.delete();
        drive();
        run_until(4'b0101, 100, "prio_drain", used);
        chk("prio_order", grants(), PRIO ? 64'h000222 : 64'h202020);
        load(1, 2, 2, 6);
        load(2, 2, 2, 6);
        gl.delete();
        drive();
        run_until(4'b0110, 100, "pair_drain", used);
        chk("pair_order", grants(), 64'h1212);

        // randomized worms, valid gaps and backpressure
        for (int n = 0; n < 40; n++) begin
            int ch, len;
            ch  = $urandom_range(N - 1);
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                flit_t fl;
                fl.d = W'($urandom);
                fl.f = (k == 0) || ($urandom_range(9) == 0);
                fl.l = (k == len - 1);
                q[ch].push_back(fl);
            end
        end
        for (int c = 0; c < 300; c++) begin
            vprob = $urandom_range(40, 100);
            rprob = $urandom_range(20, 100);
            step();
        end
        vprob = 100;
        rprob = 100;
        run_until('1, 400, "random_drain", used);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
